ov7670_tx: RTL and testbench

OV7670_TX -- requirements
Module: ov7670_tx

---
 rtl/ov7670_pkg.sv | 35 +++
 rtl/ov7670_line_timer.sv | 33 +++
 rtl/ov7670_tx.sv | 113 +++++++++++
 tb/tb_ov7670_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared OV7670 timing defaults and FSM state codes.
// The receiver side uses the same definitions.
package ov7670_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_VSYNC  = 3'd1;
   localparam state_t ST_VBACK  = 3'd2;
   localparam state_t ST_ACTIVE = 3'd3;
   localparam state_t ST_VFRONT = 3'd4;

   localparam int unsigned DEF_H_ACTIVE = 1280;
   localparam int unsigned DEF_H_BLANK  = 288;
   localparam int unsigned DEF_V_SYNC   = 3;
   localparam int unsigned DEF_V_BACK   = 17;
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FRONT  = 10;

   // Counter width able to hold 0..n-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/ov7670_line_timer.sv
// Horizontal counter for one line of L = H_ACTIVE + H_BLANK cycles.
// Held at zero while run is low; line_end marks the last cycle of a line.
module ov7670_line_timer
   import ov7670_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_BLANK  = DEF_H_BLANK,
   localparam int unsigned L  = H_ACTIVE + H_BLANK,
   localparam int unsigned HW = cnt_width(L)
)(
   input  logic          pclk,
   input  logic          reset,
   input  logic          run,
   output logic [HW-1:0] h,
   output logic          line_end
);

   logic at_last;

   assign at_last  = (h == HW'(L - 1));
   assign line_end = run && at_last;

   always_ff @(posedge pclk) begin
      if (reset || !run) begin
         h <= '0;
      end else if (at_last) begin
         h <= '0;
      end else begin
         h <= h + 1'b1;
      end
   end

endmodule

// File: rtl/ov7670_tx.sv
// OV7670-style camera output generator: frame FSM and line counter,
// one-cycle registered data path with sticky underrun flag.
module ov7670_tx
   import ov7670_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_BLANK  = DEF_H_BLANK,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BACK   = DEF_V_BACK,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FRONT  = DEF_V_FRONT
)(
   input  logic       pclk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   input  logic       underrun_clr,
   output logic       vsync,
   output logic       href,
   output logic [7:0] dout,
   output logic       frame_start,
   output logic       underrun
);

   localparam int unsigned L  = H_ACTIVE + H_BLANK;
   localparam int unsigned HW = cnt_width(L);
   localparam int unsigned VW = cnt_width(max4(V_SYNC, V_BACK, V_ACTIVE, V_FRONT));

   state_t        state;
   state_t        next_phase;
   logic [HW-1:0] h;
   logic          line_end;
   logic [VW-1:0] v;
   logic [VW-1:0] v_last;

   ov7670_line_timer #(
      .H_ACTIVE (H_ACTIVE),
      .H_BLANK  (H_BLANK)
   ) u_line_timer (
      .pclk     (pclk),
      .reset    (reset),
      .run      (state != ST_IDLE),
      .h        (h),
      .line_end (line_end)
   );

   // v counts lines within the current phase and restarts at each phase change.
   always_comb begin
      v_last     = '0;
      next_phase = ST_IDLE;
      case (state)
         ST_VSYNC: begin
            v_last     = VW'(V_SYNC - 1);
            next_phase = ST_VBACK;
         end
         ST_VBACK: begin
            v_last     = VW'(V_BACK - 1);
            next_phase = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            v_last     = VW'(V_ACTIVE - 1);
            next_phase = ST_VFRONT;
         end
         ST_VFRONT: begin
            v_last     = VW'(V_FRONT - 1);
            next_phase = enable ? ST_VSYNC : ST_IDLE;
         end
         default: begin
            v_last     = '0;
            next_phase = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         state <= ST_IDLE;
         v     <= '0;
      end else if (state == ST_IDLE) begin
         v <= '0;
         if (enable) state <= ST_VSYNC;
      end else if (line_end) begin
         if (v == v_last) begin
            v     <= '0;
            state <= next_phase;
         end else begin
            v <= v + 1'b1;
         end
      end
   end

   assign din_ready = (state == ST_ACTIVE) && (h < HW'(H_ACTIVE));

   always_ff @(posedge pclk) begin
      if (reset) begin
         vsync       <= 1'b0;
         href        <= 1'b0;
         dout        <= 8'h00;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         vsync       <= (state == ST_VSYNC);
         frame_start <= (state == ST_VSYNC) && (h == '0) && (v == '0);
         href        <= din_ready;
         dout        <= (din_ready && din_valid) ? din : 8'h00;
         // A new underrun takes priority over a clear in the same cycle.
         underrun    <= (din_ready && !din_valid) || (underrun && !underrun_clr);
      end
   end

endmodule

// File: tb/tb_ov7670_tx.sv
// Self-checking bench for ov7670_tx using a frame-position model
// and a byte scoreboard for the data path.
module tb_ov7670_tx;

   localparam int unsigned HA    = 4;
   localparam int unsigned HB    = 2;
   localparam int unsigned VS    = 1;
   localparam int unsigned VB    = 1;
   localparam int unsigned VA    = 2;
   localparam int unsigned VF    = 1;
   localparam int unsigned L     = HA + HB;
   localparam int unsigned FRAME = L * (VS + VB + VA + VF);

   logic       pclk = 1'b0;
   logic       reset;
   logic       enable;
   logic [7:0] din;
   logic       din_valid;
   logic       din_ready;
   logic       underrun_clr;
   logic       vsync;
   logic       href;
   logic [7:0] dout;
   logic       frame_start;
   logic       underrun;

   ov7670_tx #(
      .H_ACTIVE (HA),
      .H_BLANK  (HB),
      .V_SYNC   (VS),
      .V_BACK   (VB),
      .V_ACTIVE (VA),
      .V_FRONT  (VF)
   ) dut (
      .pclk         (pclk),
      .reset        (reset),
      .enable       (enable),
      .din          (din),
      .din_valid    (din_valid),
      .din_ready    (din_ready),
      .underrun_clr (underrun_clr),
      .vsync        (vsync),
      .href         (href),
      .dout         (dout),
      .frame_start  (frame_start),
      .underrun     (underrun)
   );

   always #5 pclk = ~pclk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;

   bit          m_busy  = 1'b0;
   int unsigned m_pos   = 0;
   bit          m_under = 1'b0;
   logic [7:0]  next_byte = 8'h10;
   logic [7:0]  sb[$];
   int unsigned fs_cyc[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit model_ready();
      int unsigned line;
      line = m_pos / L;
      return m_busy && (line >= VS + VB) && (line < VS + VB + VA) && ((m_pos % L) < HA);
   endfunction

   // One clock: drive inputs, check din_ready, then check registered outputs.
   task automatic step(input bit rst, input bit en, input bit valid, input bit clr);
      bit         rdy;
      bit         exp_vs;
      bit         exp_fs;
      logic [7:0] exp_byte;
      @(negedge pclk);
      reset        = rst;
      enable       = en;
      din_valid    = valid;
      din          = next_byte;
      underrun_clr = clr;
      rdy          = model_ready();
      #1;
      check_eq("din_ready", din_ready, rdy);
      exp_vs = m_busy && (m_pos < VS * L);
      exp_fs = m_busy && (m_pos == 0);
      if (!rst && rdy) begin
         sb.push_back(valid ? next_byte : 8'h00);
         if (valid) next_byte++;
      end
      @(posedge pclk);
      #1;
      cyc++;
      if (rst) begin
         m_busy  = 1'b0;
         m_pos   = 0;
         m_under = 1'b0;
         exp_vs  = 1'b0;
         exp_fs  = 1'b0;
         rdy     = 1'b0;
         sb.delete();
      end else begin
         m_under = (rdy && !valid) || (m_under && !clr);
         if (!m_busy) begin
            if (en) begin
               m_busy = 1'b1;
               m_pos  = 0;
            end
         end else if (m_pos == FRAME - 1) begin
            m_pos  = 0;
            m_busy = en;
         end else begin
            m_pos++;
         end
      end
      check_eq("vsync", vsync, exp_vs);
      check_eq("frame_start", frame_start, exp_fs);
      check_eq("href", href, rdy);
      check_eq("underrun", underrun, m_under);
      check_eq("vs_href_excl", vsync & href, 0);
      if (rdy) begin
         if (sb.size() == 0) begin
            check_eq("sb_depth", sb.size(), 1);
         end else begin
            exp_byte = sb.pop_front();
            check_eq("dout", dout, exp_byte);
         end
      end else begin
         check_eq("dout_idle", dout, 8'h00);
      end
      if (frame_start) fs_cyc.push_back(cyc);
   endtask

   initial begin
      int unsigned c0;
      int unsigned n_fs;
      bit          hit;
      reset        = 1'b1;
      enable       = 1'b0;
      din          = 8'h00;
      din_valid    = 1'b0;
      underrun_clr = 1'b0;
      repeat (2) @(posedge pclk);

      step(1, 0, 1, 0);
      repeat (3) step(0, 0, 1, 0);

      // Continuous frames with enable held high.
      step(0, 1, 1, 0);
      c0 = cyc;
      repeat (2 * FRAME + 2) step(0, 1, 1, 0);
      check_eq("fs_count", (fs_cyc.size() >= 2), 1);
      if (fs_cyc.size() >= 2) begin
         check_eq("fs_first", fs_cyc[0] - c0, 1);
         check_eq("fs_period", fs_cyc[1] - fs_cyc[0], FRAME);
      end

      // Missing second byte of the first active line.
      repeat (FRAME) step(0, 1, !(m_busy && m_pos == (VS + VB) * L + 1), 0);
      repeat (3) step(0, 1, 1, 0);
      step(0, 1, 1, 1);
      repeat (2) step(0, 1, 1, 0);

      // Clear asserted in the same cycle as a fresh underrun.
      for (int i = 0; i < FRAME; i++) begin
         hit = m_busy && (m_pos == (VS + VB + 1) * L + 2);
         step(0, 1, !hit, hit);
      end
      step(0, 1, 1, 1);

      // Drop enable mid-frame; the frame still runs to completion.
      for (int i = 0; i < 2 * FRAME && !(m_busy && m_pos == 5); i++) step(0, 1, 1, 0);
      repeat (FRAME + 10) step(0, 0, 1, 0);

      // Reset while href is high, then restart.
      for (int i = 0; i < 2 * FRAME && !(m_busy && m_pos == (VS + VB) * L + 2); i++)
         step(0, 1, 1, 0);
      step(1, 1, 1, 0);
      n_fs = fs_cyc.size();
      repeat (FRAME + 5) step(0, 1, 1, 0);
      check_eq("fs_after_reset", (fs_cyc.size() > n_fs), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
